fir_coeff_loader: RTL
=====================

Name: fir_coeff_loader

Overview:
- Multi-channel coefficient loader for the adaptive FIR.
- Passively snoops AXI-Lite AW and W handshakes and decodes writes that fall in a coefficient address window.
- Stores each decoded coefficient in a per-channel shadow RAM.
- On a commit request, streams the selected channel's coefficients to the FIR core over a valid/ready interface, with index, channel and last tags.

Parameters:
- MAX_TAPS, 16, shadow depth per channel; power of two, >= 2.
- COEFF_W, 16, coefficient width; low COEFF_W bits of WDATA are used.
- NUM_CH, 2, number of FIR channels; >= 1.
- COEFF_BASE, 32'h0000_0100, byte address of tap 0; 4-byte stride per tap.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- control_reg  in  32  bit1 load_en, bit2 commit (rising edge), bit3 clr_err, bits[7:4] channel select, bits[15:8] num_taps.
- S_AXI_AWREADY  in  1  AW ready, monitored.
- S_AXI_AWVALID  in  1  AW valid, monitored.
- S_AXI_AWADDR  in  32  AW address.
- S_AXI_WREADY  in  1  W ready, monitored.
- S_AXI_WVALID  in  1  W valid, monitored.
- S_AXI_WDATA  in  32  W data.
- coeff_valid  out  1  stream beat valid.
- coeff_ready  in  1  FIR accepts beat.
- coeff_data  out  COEFF_W  coefficient.
- coeff_idx  out  $clog2(MAX_TAPS)  tap index.
- coeff_ch  out  $clog2(NUM_CH) (min 1)  channel.
- coeff_last  out  1  final tap of the stream.
- busy  out  1  FSM not IDLE.
- load_done  out  1  one-cycle pulse after the last beat is accepted.
- err_range  out  1  sticky: decoded write outside the window or beyond MAX_TAPS.
- err_busy  out  1  sticky: coefficient write dropped during streaming.
- wr_count  out  $clog2(MAX_TAPS)+1  shadow writes since last commit; saturates at MAX_TAPS.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; capture registers empty. Shadow RAM contents are not reset.
- Capture:
  - An AW handshake (AWVALID&&AWREADY) latches AWADDR and sets aw_pend.
  - A W handshake latches WDATA and sets w_pend.
  - AW and W may arrive in either order or in the same cycle.
  - When aw_pend&&w_pend (including same-cycle arrival), a pair is formed on the next cycle and both flags clear.
  - A new handshake in the pairing cycle is captured, not lost.
- Decode, per pair, only when load_en=1:
  - idx = (addr-COEFF_BASE)>>2.
  - In window: addr>=COEFF_BASE, addr[1:0]==0 and idx<MAX_TAPS.
  - In window and IDLE: shadow[ch][idx] <= WDATA[COEFF_W-1:0]; wr_count++ (saturating).
  - In window and not IDLE: write dropped; err_busy set.
  - Outside window but within COEFF_BASE + 4*2*MAX_TAPS: err_range set.
  - Addresses outside that range are ignored silently (other registers).
- Pair with load_en=0: discarded, no error.
- Channel select: ch = control_reg[7:4], sampled at pairing. ch>=NUM_CH is treated as a range error; no write.
- Commit: rising edge of control_reg[2] detected with a 1-cycle registered copy; ignored unless IDLE.
  - ntaps = control_reg[15:8]; 0 is treated as MAX_TAPS; values >MAX_TAPS clamp to MAX_TAPS.
  - ch and ntaps are frozen for the whole stream.
- FSM:
  - IDLE: on commit, issue RAM read of idx 0 and go to FETCH.
  - FETCH: one cycle of RAM read latency, then go to STREAM.
  - STREAM: coeff_valid=1. Data, idx, ch and last stay stable until coeff_valid&&coeff_ready.
    - Handshake with idx<ntaps-1: idx++; next entry prefetched so a new beat is valid the next cycle (no bubble while ready stays high).
    - Handshake with idx==ntaps-1: go to DONE.
  - DONE: load_done=1 for one cycle; wr_count clears; go to IDLE.
- coeff_last = (idx==ntaps-1) while valid.
- Latency: commit edge to first coeff_valid is 2 cycles.
- clr_err=1: clears err_range and err_busy the next cycle. If an error and a clear occur in the same cycle, set wins.
- rst mid-stream: stream aborts at once; coeff_valid 0 next cycle; no load_done.

Test Plan:
- AW at addr 0x100 then W data 0xABCD 3 cycles later, ch0, load_en=1; commit ntaps=1 -> one beat: data 0xABCD, idx0, last=1; load_done pulses once.
- Same-cycle AW+W writes to taps 0..15 on ch1 (data 0x10+i); commit ntaps=0 with coeff_ready held 1 -> 16 consecutive beats, data 0x10..0x1F, last on idx15, ch=1.
- W before AW, and a second AW in the pairing cycle -> both writes land at the correct taps; wr_count=2.
- Write to 0x140 (idx16) and to a misaligned 0x102 -> err_range=1; shadow unchanged. clr_err -> err_range=0.
- Write to tap 2 during STREAM with coeff_ready toggling 1/0 -> err_busy=1; data/idx stable while ready=0; tap 2 old value is streamed.
- rst asserted on beat 3 of 8 -> outputs 0 next cycle; no load_done. New commit afterwards streams from idx0.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// AXI-Lite snoop inputs and the coefficient stream towards the FIR core.
// Stream rule: a beat transfers on a rising clk edge where coeff_valid && coeff_ready; while
// coeff_valid is high and coeff_ready is low, data/idx/ch/last hold and valid never drops.
interface fir_coeff_loader_if #(
  parameter int COEFF_W  = 16,
  parameter int MAX_TAPS = 16,
  parameter int NUM_CH   = 2
);
  localparam int IDX_W = $clog2(MAX_TAPS);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               S_AXI_AWREADY;
  logic               S_AXI_AWVALID;
  logic [31:0]        S_AXI_AWADDR;
  logic               S_AXI_WREADY;
  logic               S_AXI_WVALID;
  logic [31:0]        S_AXI_WDATA;
  logic               coeff_valid;
  logic               coeff_ready;
  logic [COEFF_W-1:0] coeff_data;
  logic [IDX_W-1:0]   coeff_idx;
  logic [CH_W-1:0]    coeff_ch;
  logic               coeff_last;

  modport master (
    input  S_AXI_AWREADY, S_AXI_AWVALID, S_AXI_AWADDR,
    input  S_AXI_WREADY, S_AXI_WVALID, S_AXI_WDATA,
    input  coeff_ready,
    output coeff_valid, coeff_data, coeff_idx, coeff_ch, coeff_last
  );

  modport slave (
    output S_AXI_AWREADY, S_AXI_AWVALID, S_AXI_AWADDR,
    output S_AXI_WREADY, S_AXI_WVALID, S_AXI_WDATA,
    output coeff_ready,
    input  coeff_valid, coeff_data, coeff_idx, coeff_ch, coeff_last
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Snoops AXI-Lite writes into per-channel coefficient shadow RAMs and streams a channel
// to the FIR core on a commit edge.
module fir_coeff_loader #(
  parameter int          MAX_TAPS   = 16,
  parameter int          COEFF_W    = 16,
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] COEFF_BASE = 32'h0000_0100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   control_reg,
  fir_coeff_loader_if.master            bus,
  output logic                          busy,
  output logic                          load_done,
  output logic                          err_range,
  output logic                          err_busy,
  output logic [$clog2(MAX_TAPS):0]     wr_count,
  output logic [1:0]                    fsm_state
);
  localparam int IDX_W = $clog2(MAX_TAPS);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0]    WIN_BYTES = 32'(4 * MAX_TAPS);
  localparam logic [31:0]    DEC_BYTES = 32'(8 * MAX_TAPS);
  localparam logic [IDX_W:0] WC_MAX    = (IDX_W + 1)'(MAX_TAPS);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;
  state_t state;

  logic load_en, clr_err;
  logic [3:0]  ch_raw;
  logic [31:0] nt32;
  assign load_en = control_reg[1];
  assign clr_err = control_reg[3];
  assign ch_raw  = control_reg[7:4];
  assign nt32    = {24'd0, control_reg[15:8]};

  logic unused_ctrl;
  assign unused_ctrl = ^{control_reg[31:16], control_reg[0]};

  // Capture: a handshake in the pairing cycle re-arms its flag (set beats clear)
  logic        aw_hs, w_hs, aw_pend, w_pend, pair;
  logic [31:0] aw_addr_q, w_data_q;
  assign aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
  assign w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
  assign pair  = aw_pend && w_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= bus.S_AXI_AWADDR;
        aw_pend   <= 1'b1;
      end else if (pair) begin
        aw_pend <= 1'b0;
      end
      if (w_hs) begin
        w_data_q <= bus.S_AXI_WDATA;
        w_pend   <= 1'b1;
      end else if (pair) begin
        w_pend <= 1'b0;
      end
    end
  end

  // Decode of the formed pair against the tap window and the wider error window
  logic [31:0]       off;
  logic              above_base, in_dec, in_win, ch_ok, dec_hit;
  logic              do_write, set_busy, set_range;
  logic [IDX_W-1:0]  wr_idx;
  logic [CH_W-1:0]   sel_ch;
  assign off        = aw_addr_q - COEFF_BASE;
  assign above_base = aw_addr_q >= COEFF_BASE;
  assign in_dec     = above_base && (off < DEC_BYTES);
  assign in_win     = above_base && (aw_addr_q[1:0] == 2'b00) && (off < WIN_BYTES);
  assign ch_ok      = {28'd0, ch_raw} < 32'(NUM_CH);
  assign sel_ch     = ch_ok ? ch_raw[CH_W-1:0] : '0;
  assign wr_idx     = off[IDX_W+1:2];
  assign dec_hit    = pair && load_en && in_dec;
  assign do_write   = dec_hit && in_win && ch_ok && (state == IDLE);
  assign set_busy   = dec_hit && in_win && ch_ok && (state != IDLE);
  assign set_range  = dec_hit && !(in_win && ch_ok);

  logic unused_wdata;
  assign unused_wdata = ^w_data_q;

  logic [COEFF_W-1:0] shadow [NUM_CH][MAX_TAPS];
  always_ff @(posedge clk) begin
    if (do_write) shadow[sel_ch][wr_idx] <= w_data_q[COEFF_W-1:0];
  end

  // Stream-side registers
  logic               commit_q, commit_edge, valid_q, last_flag;
  logic [IDX_W-1:0]   idx_q, last_q, last_cmb, rd_idx;
  logic [CH_W-1:0]    ch_q, rd_ch;
  logic [COEFF_W-1:0] rd_data;
  assign commit_edge = control_reg[2] && !commit_q;
  assign last_cmb = ((nt32 == 32'd0) || (nt32 > 32'(MAX_TAPS))) ? IDX_W'(MAX_TAPS - 1)
                                                                : IDX_W'(nt32 - 32'd1);

  // Read address runs one step ahead so the next beat is ready on the cycle after a handshake
  always_comb begin
    rd_ch  = ch_q;
    rd_idx = idx_q;
    case (state)
      IDLE:   begin
        rd_ch  = sel_ch;
        rd_idx = '0;
      end
      STREAM: if (bus.coeff_ready && (idx_q != last_q)) rd_idx = idx_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= shadow[rd_ch][rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      commit_q  <= 1'b0;
      valid_q   <= 1'b0;
      last_flag <= 1'b0;
      idx_q     <= '0;
      last_q    <= '0;
      ch_q      <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      commit_q  <= control_reg[2];
      load_done <= 1'b0;
      case (state)
        IDLE: if (commit_edge) begin
          state  <= FETCH;
          busy   <= 1'b1;
          ch_q   <= sel_ch;
          last_q <= last_cmb;
          idx_q  <= '0;
        end
        FETCH: begin
          state     <= STREAM;
          valid_q   <= 1'b1;
          last_flag <= (last_q == '0);
        end
        STREAM: if (bus.coeff_ready) begin
          if (idx_q == last_q) begin
            state     <= DONE;
            valid_q   <= 1'b0;
            last_flag <= 1'b0;
            load_done <= 1'b1;
          end else begin
            idx_q     <= idx_q + 1'b1;
            last_flag <= ((idx_q + 1'b1) == last_q);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count  <= '0;
      err_range <= 1'b0;
      err_busy  <= 1'b0;
    end else begin
      if (state == DONE)                     wr_count <= '0;
      else if (do_write && wr_count != WC_MAX) wr_count <= wr_count + 1'b1;
      if (set_range)    err_range <= 1'b1;
      else if (clr_err) err_range <= 1'b0;
      if (set_busy)     err_busy <= 1'b1;
      else if (clr_err) err_busy <= 1'b0;
    end
  end

  assign bus.coeff_valid = valid_q;
  assign bus.coeff_data  = rd_data;
  assign bus.coeff_idx   = idx_q;
  assign bus.coeff_ch    = ch_q;
  assign bus.coeff_last  = last_flag;
  assign fsm_state       = state;
endmodule
